// File: rtl/hpi_bus_master_if.sv
// Command/response bus between a host-side client and hpi_bus_master.
// The master modport is the client; the slave modport is the bus master engine.
interface hpi_bus_master_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    // A command transfers on a clock edge where cmd_valid and cmd_ready are both high.
    // cmd_ready is high only while the engine is idle. The client may raise cmd_valid
    // at any time; while cmd_ready is low, cmd_valid and the cmd_* fields are ignored.
    // rsp_valid and beat_req are single-cycle pulses with no backpressure.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [LEN_W-1:0]  cmd_len;
    logic              beat_req;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        input  cmd_ready, beat_req, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        output cmd_ready, beat_req, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/hpi_bus_master.sv
// CY7C67300 HPI bus master with programmable setup/strobe/hold/turnaround timing.
// Optional burst mode (repeated DATA-port beats) is enabled by defining HPI_BURST_EN.
module hpi_bus_master #(
    parameter int DATA_W     = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 6,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 2,
    parameter int RST_CYC    = 64,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    hpi_bus_master_if.slave   bus,
    output logic              hpi_resetn,
    output logic              hpi_csn,
    output logic              hpi_oen,
    output logic              hpi_wen,
    output logic [1:0]        hpi_address,
    output logic [DATA_W-1:0] hpi_data_o,
    output logic              hpi_data_oe,
    input  logic [DATA_W-1:0] hpi_data_i,
    input  logic              hpi_irq,
    output logic              irq_level,
    output logic              irq_rise,
    output logic [2:0]        state_dbg
);

    localparam int CNT_MAX = RST_CYC + SETUP_CYC + STROBE_CYC + HOLD_CYC + TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_RSTHOLD = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_STROBE  = 3'd3,
        S_HOLD    = 3'd4,
        S_TURN    = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_write;
    logic               cmd_ready_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               beat_req_r;
    logic               busy_r;
    logic               more;
    logic               irq_meta;

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.beat_req  = beat_req_r;
    assign bus.busy      = busy_r;
    assign state_dbg     = state;

`ifdef HPI_BURST_EN
    // Remaining beats after the current one; stops at zero, never wraps.
    logic [LEN_W-1:0] beats_left;
    assign more = (beats_left != '0);
`else
    logic unused_len;
    assign unused_len = ^bus.cmd_len;
    assign more       = 1'b0;
`endif

    // Each phase loads cnt with (length-1) on entry and leaves when it reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RSTHOLD;
            cnt         <= CNT_W'(RST_CYC - 1);
            lat_write   <= 1'b0;
            hpi_resetn  <= 1'b0;
            hpi_csn     <= 1'b1;
            hpi_oen     <= 1'b1;
            hpi_wen     <= 1'b1;
            hpi_address <= 2'd0;
            hpi_data_o  <= '0;
            hpi_data_oe <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            beat_req_r  <= 1'b0;
            busy_r      <= 1'b1;
`ifdef HPI_BURST_EN
            beats_left  <= '0;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            beat_req_r  <= 1'b0;
            case (state)
                S_RSTHOLD: begin
                    if (cnt == '0) begin
                        hpi_resetn  <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        lat_write   <= bus.cmd_write;
                        hpi_address <= bus.cmd_addr;
                        if (bus.cmd_write) hpi_data_o <= bus.cmd_wdata;
                        hpi_data_oe <= bus.cmd_write;
                        hpi_csn     <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef HPI_BURST_EN
                        beats_left  <= bus.cmd_len;
`endif
                        cnt         <= CNT_W'(SETUP_CYC - 1);
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        if (lat_write) hpi_wen <= 1'b0;
                        else           hpi_oen <= 1'b0;
                        cnt   <= CNT_W'(STROBE_CYC - 1);
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        hpi_oen <= 1'b1;
                        hpi_wen <= 1'b1;
                        if (!lat_write) begin
                            rsp_rdata_r <= hpi_data_i;
                            rsp_valid_r <= 1'b1;
                        end
                        cnt   <= CNT_W'(HOLD_CYC - 1);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        hpi_csn     <= 1'b1;
                        hpi_data_oe <= 1'b0;
                        // With a single turnaround cycle, the request lands in that cycle.
                        beat_req_r  <= (TURN_CYC == 1) && more && lat_write;
                        cnt         <= CNT_W'(TURN_CYC - 1);
                        state       <= S_TURN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_TURN: begin
                    if (cnt == '0) begin
                        if (more) begin
                            if (lat_write) hpi_data_o <= bus.cmd_wdata;
                            hpi_data_oe <= lat_write;
                            hpi_csn     <= 1'b0;
`ifdef HPI_BURST_EN
                            beats_left  <= beats_left - 1'b1;
`endif
                            cnt         <= CNT_W'(SETUP_CYC - 1);
                            state       <= S_SETUP;
                        end else begin
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else begin
                        beat_req_r <= (cnt == CNT_W'(1)) && more && lat_write;
                        cnt        <= cnt - 1'b1;
                    end
                end
                default: begin
                    hpi_csn     <= 1'b1;
                    hpi_oen     <= 1'b1;
                    hpi_wen     <= 1'b1;
                    hpi_data_oe <= 1'b0;
                    hpi_resetn  <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    busy_r      <= 1'b1;
                    cnt         <= CNT_W'(RST_CYC - 1);
                    state       <= S_RSTHOLD;
                end
            endcase
        end
    end

    // Two-flop synchroniser; irq_rise is registered so it lines up with irq_level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta  <= 1'b0;
            irq_level <= 1'b0;
            irq_rise  <= 1'b0;
        end else begin
            irq_meta  <= hpi_irq;
            irq_level <= irq_meta;
            irq_rise  <= irq_meta & ~irq_level;
        end
    end

endmodule

// File: tb/tb_hpi_bus_master.sv
// Directed bench for hpi_bus_master: reset hold, single read/write beat timing,
// burst or length-ignore behaviour, mid-beat reset and INT synchronisation.
module tb_hpi_bus_master;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hpi_resetn, hpi_csn, hpi_oen, hpi_wen, hpi_data_oe;
  logic [1:0]    hpi_address;
  logic [DW-1:0] hpi_data_o;
  logic [DW-1:0] hpi_data_i = 16'hBEEF;
  logic          hpi_irq = 1'b0;
  logic          irq_level, irq_rise;
  logic [2:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wq[$];

  logic [63:0] v_csn, v_wen, v_oen, v_oe, v_rdy, v_busy, v_breq, v_rsp;
  logic [1:0]  addr_at5;

  hpi_bus_master_if #(.DATA_W(DW), .LEN_W(8)) bus ();

  hpi_bus_master dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .hpi_resetn  (hpi_resetn),
    .hpi_csn     (hpi_csn),
    .hpi_oen     (hpi_oen),
    .hpi_wen     (hpi_wen),
    .hpi_address (hpi_address),
    .hpi_data_o  (hpi_data_o),
    .hpi_data_oe (hpi_data_oe),
    .hpi_data_i  (hpi_data_i),
    .hpi_irq     (hpi_irq),
    .irq_level   (irq_level),
    .irq_rise    (irq_rise),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Assert reset for 5 cycles, check reset values, release and measure hpi_resetn low time.
  task automatic reset_seq();
    int n_low;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ctrl",
          {hpi_resetn, hpi_csn, hpi_oen, hpi_wen, hpi_address, hpi_data_oe, bus.cmd_ready,
           bus.rsp_valid, bus.beat_req, bus.busy, irq_level, irq_rise},
          {1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("rst_data", {hpi_data_o, bus.rsp_rdata}, 32'h0);
    check("rst_state", state_dbg, 3'd0);
    reset = 1'b0;
    n_low = 0;
    if (!hpi_resetn) n_low++;
    for (int i = 0; i < 200 && !hpi_resetn; i++) begin
      @(posedge clk); #1;
      if (!hpi_resetn) n_low++;
    end
    check("rsthold_low_cycles", n_low, 64);
    check("rsthold_ready", {hpi_resetn, bus.cmd_ready, bus.busy}, 3'b110);
  endtask

  // Sample cycle k of a command (cycle 0 = accept cycle) and service the scoreboard.
  task automatic sample(input int k, inout logic prev_wen);
    v_csn[k]  = hpi_csn;
    v_wen[k]  = hpi_wen;
    v_oen[k]  = hpi_oen;
    v_oe[k]   = hpi_data_oe;
    v_rdy[k]  = bus.cmd_ready;
    v_busy[k] = bus.busy;
    v_breq[k] = bus.beat_req;
    v_rsp[k]  = bus.rsp_valid;
    if (k == 5) addr_at5 = hpi_address;
    if (bus.beat_req && wq.size() > 0) bus.cmd_wdata = wq.pop_front();
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check("sb_rsp_underflow", 1, 0);
      else check("sb_rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
    end
    if (prev_wen && !hpi_wen) begin
      if (exp_q.size() == 0) check("sb_pad_underflow", 1, 0);
      else check("sb_pad_wdata", hpi_data_o, exp_q.pop_front());
    end
    prev_wen = hpi_wen;
  endtask

  // Driver: wait for cmd_ready, present one command, capture ncyc cycles of waveform.
  // cmd_valid stays high for vhold cycles; while held, addr/write are scrambled.
  task automatic run_cmd(input logic wr, input logic [1:0] a, input logic [DW-1:0] wd,
                         input logic [7:0] len, input int ncyc, input int vhold);
    int   guard;
    logic prev_wen;
    guard = 0;
    while (!bus.cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", guard < 200, 1);
    {v_csn, v_wen, v_oen, v_oe, v_rdy, v_busy, v_breq, v_rsp} = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_len   = len;
    prev_wen = 1'b1;
    sample(0, prev_wen);
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.cmd_addr  = 2'd3;
        bus.cmd_write = ~wr;
      end
      if (k == vhold) bus.cmd_valid = 1'b0;
      sample(k, prev_wen);
    end
    bus.cmd_valid = 1'b0;
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] exp_wen;
    int          first_rise;
    int          n_rise;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = '0;
    bus.cmd_len   = '0;

    // 1: power-on reset and RSTHOLD
    reset_seq();

    // 2: single write to ADDRESS port
    exp_q.push_back(16'h1000);
    run_cmd(1'b1, 2'd2, 16'h1000, 8'd0, 16, 1);
    check("wr_csn", v_csn, 64'hF801);
    check("wr_wen", v_wen, 64'hFE07);
    check("wr_oen", v_oen, 64'hFFFF);
    check("wr_data_oe", v_oe, 64'h07FE);
    check("wr_cmd_ready", v_rdy, 64'hE001);
    check("wr_busy", v_busy, 64'h1FFE);
    check("wr_addr", addr_at5, 2'd2);

    // 3: single read of DATA port, cmd_valid held into the beat (must be ignored)
    exp_q.push_back(16'hBEEF);
    run_cmd(1'b0, 2'd0, 16'h0000, 8'd0, 16, 4);
    check("rd_csn", v_csn, 64'hF801);
    check("rd_oen", v_oen, 64'hFE07);
    check("rd_wen", v_wen, 64'hFFFF);
    check("rd_data_oe", v_oe, 64'h0);
    check("rd_rsp_valid", v_rsp, 64'h0200);
    check("rd_cmd_ready", v_rdy, 64'hE001);
    check("rd_addr", addr_at5, 2'd0);
    check("rd_rdata_hold", bus.rsp_rdata, 16'hBEEF);

`ifdef HPI_BURST_EN
    // 4: burst write of 4 words to DATA port
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    wq.push_back(16'h2222);
    wq.push_back(16'h3333);
    wq.push_back(16'h4444);
    run_cmd(1'b1, 2'd0, 16'h1111, 8'd3, 52, 1);
    exp_wen = (64'd1 << 52) - 64'd1;
    for (int b = 0; b < 4; b++)
      for (int c = 3; c <= 8; c++) exp_wen[12*b + c] = 1'b0;
    check("burst_wen", v_wen, exp_wen);
    check("burst_beat_req", v_breq, (64'd1 << 12) | (64'd1 << 24) | (64'd1 << 36));
    check("burst_cmd_ready", v_rdy, 64'd1 | (64'd7 << 49));
`else
    // 4: cmd_len ignored, single beat, no beat_req
    exp_q.push_back(16'h2A2A);
    run_cmd(1'b1, 2'd1, 16'h2A2A, 8'd3, 16, 1);
    check("len_ignored_busy", v_busy, 64'h1FFE);
    check("len_ignored_wen", v_wen, 64'hFE07);
    check("len_ignored_beat_req", v_breq, 64'h0);
    check("len_ignored_addr", addr_at5, 2'd1);
`endif

    // 5: reset asserted in the middle of a write strobe
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 2'd2;
    bus.cmd_wdata = 16'h5A5A;
    bus.cmd_len   = 8'd0;
    check("t5_ready_before", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t5_in_strobe", {hpi_wen, hpi_csn, hpi_data_oe, state_dbg}, {1'b0, 1'b0, 1'b1, 3'd3});
    reset = 1'b1;
    #1;
    check("t5_async_release", {hpi_wen, hpi_oen, hpi_csn, hpi_data_oe, hpi_resetn},
          5'b11100);
    reset_seq();

    // 6: INT synchroniser
    #3 hpi_irq = 1'b1;
    first_rise = -1;
    n_rise = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (irq_rise) begin
        n_rise++;
        if (first_rise < 0) first_rise = k;
      end
    end
    check("irq_rise_latency_ok", (first_rise >= 2 && first_rise <= 3), 1'b1);
    check("irq_rise_count", n_rise, 1);
    check("irq_level_high", irq_level, 1'b1);
    hpi_irq = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("irq_level_low", {irq_level, irq_rise}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
